// File: rtl/cpu2a03_dma_pkg.sv
// cpu2a03_dma_pkg: DMA state encoding, default DMA addresses and the 2A03 APU/IO register map
package cpu2a03_dma_pkg;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HALT    = 3'd1;
   localparam logic [2:0] ST_ALIGN   = 3'd2;
   localparam logic [2:0] ST_GET     = 3'd3;
   localparam logic [2:0] ST_PUT     = 3'd4;
   localparam logic [2:0] ST_DMC_GET = 3'd5;
   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      HALT    = ST_HALT,
      ALIGN   = ST_ALIGN,
      GET     = ST_GET,
      PUT     = ST_PUT,
      DMC_GET = ST_DMC_GET
   } dma_state_e;
   localparam logic [15:0] PPU_OAMDATA_ADDR   = 16'h2004;
   localparam logic [15:0] PPU_DATA_ADDR      = 16'h2007;
   localparam logic [15:0] APU_PULSE1_ADDR    = 16'h4000;
   localparam logic [15:0] APU_PULSE2_ADDR    = 16'h4004;
   localparam logic [15:0] APU_TRIANGLE_ADDR  = 16'h4008;
   localparam logic [15:0] APU_NOISE_ADDR     = 16'h400C;
   localparam logic [15:0] APU_DMC_ADDR       = 16'h4010;
   localparam logic [15:0] OAM_DMA_ADDR       = 16'h4014;
   localparam logic [15:0] APU_STATUS_ADDR    = 16'h4015;
   localparam logic [15:0] JOY1_ADDR          = 16'h4016;
   localparam logic [15:0] APU_FRAME_CNT_ADDR = 16'h4017;
   localparam logic [15:0] DEF_TRIGGER_ADDR   = OAM_DMA_ADDR;
   localparam logic [15:0] DEF_DEST_ADDR      = PPU_OAMDATA_ADDR;
endpackage

// File: rtl/cpu2a03_cycle_parity.sv
// cpu2a03_cycle_parity: get/put parity flop, toggles on every enabled CPU cycle
//   i_clk, i_reset (sync, active-high), i_clk_en -> o_parity (0 = get slot, 1 = put slot)
module cpu2a03_cycle_parity
   import cpu2a03_dma_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clk_en,
   output logic o_parity
);
   always_ff @(posedge i_clk)
      if (i_reset) o_parity <= 1'b0;
      else if (i_clk_en) o_parity <= ~o_parity;
endmodule

// File: rtl/cpu2a03_dma_controller.sv
// cpu2a03_dma_controller: 2A03 OAM burst DMA with DMC sample-fetch arbitration
//   cpu side : i_cpu_rw/i_cpu_address/i_cpu_data watched for the trigger write, o_rdy halts the 6502
//   bus side : o_active/o_rw/o_address/o_data drive the bus while owned, i_data is read data
//   dmc side : i_dmc_req/i_dmc_address in, o_dmc_ack pulse with o_dmc_data out
module cpu2a03_dma_controller
   import cpu2a03_dma_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR = DEF_TRIGGER_ADDR,
   parameter logic [15:0] DEST_ADDR    = DEF_DEST_ADDR,
   parameter int          LENGTH       = 256,
   parameter bit          DMC_ENABLE   = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clk_en,
   input  logic        i_cpu_rw,
   input  logic [15:0] i_cpu_address,
   input  logic [7:0]  i_cpu_data,
   input  logic [7:0]  i_data,
   output logic        o_rdy,
   output logic        o_active,
   output logic        o_rw,
   output logic [15:0] o_address,
   output logic [7:0]  o_data,
   input  logic        i_dmc_req,
   input  logic [15:0] i_dmc_address,
   output logic        o_dmc_ack,
   output logic [7:0]  o_dmc_data
);
   localparam int CW = $clog2(LENGTH + 1);
   dma_state_e state, state_n, slot_st, next_get;
   logic p, burst, dmc_pend, trigger, last, start;
   logic [7:0] page;
   logic [CW-1:0] count, count_n;
   cpu2a03_cycle_parity u_parity (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clk_en (i_clk_en),
      .o_parity (p)
   );
   // the request is still high during the ack cycle; masking it stops a double fetch
   assign dmc_pend = DMC_ENABLE && i_dmc_req && !o_dmc_ack;
   assign trigger  = !i_cpu_rw && i_cpu_address == TRIGGER_ADDR;
   assign start    = state == IDLE && trigger;
   assign last     = count == CW'(LENGTH - 1);
   assign count_n  = count + CW'(state == PUT);
   assign slot_st  = dmc_pend ? DMC_GET : GET;
   assign next_get = (burst || dmc_pend) ? slot_st : IDLE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = (trigger || dmc_pend) ? HALT : IDLE;
         HALT:    state_n = !i_cpu_rw ? HALT : p ? next_get : ALIGN;
         ALIGN:   state_n = next_get;
         GET:     state_n = PUT;
         PUT:     state_n = last ? IDLE : slot_st;
         DMC_GET: state_n = ALIGN;
         default: state_n = IDLE;
      endcase
   end
   // outputs are registered from the next state so they describe the cycle being entered
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         page       <= 8'h00;
         count      <= '0;
         burst      <= 1'b0;
         o_rdy      <= 1'b1;
         o_active   <= 1'b0;
         o_rw       <= 1'b1;
         o_address  <= 16'h0000;
         o_data     <= 8'h00;
         o_dmc_ack  <= 1'b0;
         o_dmc_data <= 8'h00;
      end else if (i_clk_en) begin
         state      <= state_n;
         page       <= start ? i_cpu_data : page;
         count      <= start ? '0 : count_n;
         burst      <= start ? 1'b1 : (state == PUT && last) ? 1'b0 : burst;
         o_rdy      <= state_n == IDLE;
         o_active   <= state_n != IDLE && state_n != HALT;
         o_rw       <= state_n != PUT;
         o_address  <= state_n == GET ? {page, 8'(count_n)} :
                       state_n == DMC_GET ? i_dmc_address :
                       state_n == PUT ? DEST_ADDR : o_address;
         o_data     <= state_n == PUT ? i_data : o_data;
         o_dmc_ack  <= state == DMC_GET;
         o_dmc_data <= state == DMC_GET ? i_data : o_dmc_data;
      end
   end
endmodule

// File: tb/tb_cpu2a03_dma_controller.sv
// tb_cpu2a03_dma_controller: scoreboard bench for the default 256-byte engine and a 4-byte $2007 variant
module tb_cpu2a03_dma_controller;
   logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
   logic cpu_rw = 1'b1, cpu2_rw = 1'b1;
   logic [15:0] cpu_addr = 16'h8000, cpu2_addr = 16'h8000;
   logic [7:0] cpu_data = 8'h00, cpu2_data = 8'h00;
   logic dmc_req = 1'b0;
   logic [15:0] dmc_addr = 16'h0000;
   logic rdy, active, bus_rw, dmc_ack, rdy2, active2, bus_rw2, dmc_ack2;
   logic [15:0] addr, addr2;
   logic [7:0] wdata, wdata2, dmc_data, dmc_data2, rd_data, rd_data2;
   logic [25:0] obs1, obs2;
   logic [25:0] q1[$], q2[$];
   logic [7:0] dq[$];
   logic [15:0] la1 = 16'h0000, la2 = 16'h0000;
   bit rst_q = 1'b1, en_q = 1'b0, tp = 1'b0;
   int n_chk = 0, n_fail = 0;
   int run1 = 0, run2 = 0, last_run1 = 0, last_run2 = 0, done1 = 0, done2 = 0;

   function automatic logic [7:0] mem(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign rd_data  = mem(addr);
   assign rd_data2 = mem(addr2);
   assign obs1 = {active, bus_rw, addr, bus_rw ? 8'h00 : wdata};
   assign obs2 = {active2, bus_rw2, addr2, bus_rw2 ? 8'h00 : wdata2};

   cpu2a03_dma_controller dut (
      .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en),
      .i_cpu_rw(cpu_rw), .i_cpu_address(cpu_addr), .i_cpu_data(cpu_data),
      .i_data(rd_data), .o_rdy(rdy), .o_active(active), .o_rw(bus_rw),
      .o_address(addr), .o_data(wdata), .i_dmc_req(dmc_req),
      .i_dmc_address(dmc_addr), .o_dmc_ack(dmc_ack), .o_dmc_data(dmc_data)
   );

   cpu2a03_dma_controller #(.LENGTH(4), .DEST_ADDR(16'h2007), .DMC_ENABLE(1'b0)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en),
      .i_cpu_rw(cpu2_rw), .i_cpu_address(cpu2_addr), .i_cpu_data(cpu2_data),
      .i_data(rd_data2), .o_rdy(rdy2), .o_active(active2), .o_rw(bus_rw2),
      .o_address(addr2), .o_data(wdata2), .i_dmc_req(1'b1),
      .i_dmc_address(16'hBEEF), .o_dmc_ack(dmc_ack2), .o_dmc_data(dmc_data2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rst_q <= rst;
      en_q  <= clk_en;
      tp    <= rst ? 1'b0 : clk_en ? ~tp : tp;
   end

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_q) run1 = 0;
      else if (en_q) begin
         if (!rdy) begin
            run1++;
            if (q1.size() == 0) check("bus1_unexpected", q1.size(), 1);
            else check("bus1", obs1, q1.pop_front());
         end else if (run1 > 0) begin
            last_run1 = run1;
            run1 = 0;
            done1++;
         end
         if (dmc_ack) begin
            if (dq.size() == 0) check("dmc_unexpected", dq.size(), 1);
            else check("dmc_data", dmc_data, dq.pop_front());
            dmc_req = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_q) run2 = 0;
      else if (en_q) begin
         if (!rdy2) begin
            run2++;
            check("dmc_off", {dmc_ack2, dmc_data2}, 0);
            if (q2.size() == 0) check("bus2_unexpected", q2.size(), 1);
            else check("bus2", obs2, q2.pop_front());
         end else if (run2 > 0) begin
            last_run2 = run2;
            run2 = 0;
            done2++;
         end
      end
   end

   task automatic push1(input bit which, input logic [25:0] e);
      if (which) q2.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic push_burst(input bit which, input logic [7:0] pg, input int halts, input int len,
                             input logic [15:0] dest, input int steal_at, input logic [15:0] dmc_a);
      logic [15:0] la, a;
      bit cp;
      la = which ? la2 : la1;
      cp = tp;
      repeat (halts) begin
         cp = ~cp;
         push1(which, {1'b0, 1'b1, la, 8'h00});
      end
      if (!cp) push1(which, {1'b1, 1'b1, la, 8'h00});
      for (int i = 0; i <= len; i++) begin
         if (i == steal_at) begin
            push1(which, {1'b1, 1'b1, dmc_a, 8'h00});
            push1(which, {1'b1, 1'b1, dmc_a, 8'h00});
            la = dmc_a;
         end
         if (i == len) break;
         a = {pg, 8'(i)};
         push1(which, {1'b1, 1'b1, a, 8'h00});
         push1(which, {1'b1, 1'b0, dest, mem(a)});
         la = dest;
      end
      if (which) la2 = la;
      else la1 = la;
   endtask

   task automatic drive(input bit which, input logic rw, input logic [15:0] a, input logic [7:0] d);
      if (which) begin
         cpu2_rw = rw; cpu2_addr = a; cpu2_data = d;
      end else begin
         cpu_rw = rw; cpu_addr = a; cpu_data = d;
      end
   endtask

   task automatic trig(input bit which, input logic [7:0] pg, input int extra);
      drive(which, 1'b0, 16'h4014, pg);
      @(negedge clk);
      repeat (extra) begin
         drive(which, 1'b0, 16'h01FF, 8'hEE);
         @(negedge clk);
      end
      drive(which, 1'b1, 16'h8000, 8'h00);
   endtask

   task automatic align_p(input bit want);
      @(negedge clk);
      for (int i = 0; i < 4 && tp != want; i++) @(negedge clk);
   endtask

   task automatic wait_run(input bit which, input int exp, input string tag);
      int d0;
      bit ok;
      d0 = which ? done2 : done1;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = (which ? done2 : done1) != d0;
      end
      check(tag, ok ? (which ? last_run2 : last_run1) : -1, exp);
      check({tag, "_drain"}, which ? q2.size() : q1.size(), 0);
   endtask

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      check("reset1", {rdy, active, bus_rw, addr, wdata, dmc_ack, dmc_data}, {1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0, 8'h0});
      check("reset2", {rdy2, active2, bus_rw2, addr2, wdata2, dmc_ack2, dmc_data2}, {1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0, 8'h0});
      rst = 1'b0;
      align_p(1'b0);
      push_burst(1'b0, 8'h02, 1, 256, 16'h2004, -1, 16'h0);
      trig(1'b0, 8'h02, 0);
      wait_run(1'b0, 513, "oam_halt_p1");
      align_p(1'b1);
      push_burst(1'b0, 8'h02, 1, 256, 16'h2004, -1, 16'h0);
      trig(1'b0, 8'h02, 0);
      wait_run(1'b0, 514, "oam_halt_p0");
      align_p(1'b0);
      push_burst(1'b0, 8'h02, 3, 256, 16'h2004, -1, 16'h0);
      trig(1'b0, 8'h02, 2);
      wait_run(1'b0, 515, "oam_halt_writes");
      align_p(1'b0);
      push_burst(1'b0, 8'h02, 1, 256, 16'h2004, 8'h41, 16'hC123);
      trig(1'b0, 8'h02, 0);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         ok = active && !bus_rw && wdata == mem(16'h0240);
      end
      check("steal_point", ok, 1);
      dmc_addr = 16'hC123;
      dmc_req = 1'b1;
      dq.push_back(mem(16'hC123));
      wait_run(1'b0, 515, "oam_dmc_steal");
      check("steal_acked", dq.size(), 0);
      align_p(1'b0);
      push_burst(1'b1, 8'h03, 1, 4, 16'h2007, -1, 16'h0);
      trig(1'b1, 8'h03, 0);
      wait_run(1'b1, 9, "len4_halt_p1");
      align_p(1'b1);
      push_burst(1'b1, 8'h03, 1, 4, 16'h2007, -1, 16'h0);
      trig(1'b1, 8'h03, 0);
      repeat (2) @(negedge clk);
      clk_en = 1'b0;
      repeat (3) @(negedge clk);
      clk_en = 1'b1;
      wait_run(1'b1, 10, "len4_halt_p0_hold");
      align_p(1'b0);
      push_burst(1'b0, 8'h02, 1, 256, 16'h2004, -1, 16'h0);
      trig(1'b0, 8'h02, 0);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         ok = active && bus_rw && addr == 16'h0280;
      end
      check("reset_point", ok, 1);
      rst = 1'b1;
      @(negedge clk);
      check("reset_abort", {rdy, active}, 2'b10);
      rst = 1'b0;
      q1.delete();
      la1 = 16'h0000;
      la2 = 16'h0000;
      @(negedge clk);
      check("reset_idle", {rdy, active}, 2'b10);
      align_p(1'b0);
      push_burst(1'b0, 8'h02, 1, 256, 16'h2004, -1, 16'h0);
      trig(1'b0, 8'h02, 0);
      wait_run(1'b0, 513, "restart");
      align_p(1'b0);
      dmc_addr = 16'hC456;
      dmc_req = 1'b1;
      dq.push_back(mem(16'hC456));
      push_burst(1'b0, 8'h00, 1, 0, 16'h2004, 0, 16'hC456);
      wait_run(1'b0, 3, "dmc_solo");
      check("solo_acked", dq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
